// File: rtl/pipe_pkg.sv
// pipe_pkg: shared fetch-stage constants and the fetch FSM state type.
package pipe_pkg;
    localparam int INSTR_W = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} fetch_state_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry register parking an acked instruction word while decode stalls.
// Ports: clk, rst_n (sync, active-low), load (capture d), clr (drop entry), d (word in),
//        q (held word), valid (entry occupied).
module fetch_skid_buf
    import pipe_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               clr,
    input  logic [INSTR_W-1:0] d,
    output logic [INSTR_W-1:0] q,
    output logic               valid
);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (load) begin
            q     <= d;
            valid <= 1'b1;
        end else if (clr) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: fetch PC generator, one-outstanding imem req/ack master and F/D register.
// Ports: clk, rst_n (sync, active-low); stall_i freezes F/D; redirect_i/redirect_pc_i from decode;
//        imem_req_o/imem_addr_o/imem_ack_i/imem_rdata_i to instruction memory;
//        instr_d_o/pc4_d_o/valid_d_o form the F/D register.
module fetch_pc_unit
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_d_o,
    output logic [31:0] pc4_d_o,
    output logic        valid_d_o
);
    fetch_state_t state, state_nx;
    logic [31:0] pc, pc4, pend_pc, next_pc, skid_q;
    logic pend_v, accept, ack_ok, skid_load, retire, skid_v;

    fetch_skid_buf u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .clr   (retire && state == HOLD),
        .d     (imem_rdata_i),
        .q     (skid_q),
        .valid (skid_v)
    );

    always_comb begin
        pc4       = pc + 32'd4;
        accept    = redirect_i && !stall_i;
        next_pc   = accept ? redirect_pc_i : pend_v ? pend_pc : pc4;
        ack_ok    = state == FETCH && imem_ack_i;
        skid_load = ack_ok && stall_i;
        // the current word leaves fetch either straight from memory or from the skid
        retire    = (ack_ok || state == HOLD) && !stall_i;
        state_nx  = state;
        case (state)
            IDLE:    state_nx = FETCH;
            FETCH:   state_nx = skid_load ? HOLD : FETCH;
            HOLD:    state_nx = stall_i ? HOLD : FETCH;
            default: state_nx = IDLE;
        endcase
    end

    assign imem_req_o  = state == FETCH;
    assign imem_addr_o = pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            pend_v    <= 1'b0;
            pend_pc   <= '0;
            instr_d_o <= '0;
            pc4_d_o   <= '0;
            valid_d_o <= 1'b0;
        end else begin
            state <= state_nx;
            if (retire) begin
                // delay slot enters F/D; any redirect only steers the following address
                pc        <= next_pc;
                pend_v    <= 1'b0;
                instr_d_o <= state == HOLD ? skid_q : imem_rdata_i;
                pc4_d_o   <= pc4;
                valid_d_o <= state == HOLD ? skid_v : 1'b1;
            end else begin
                if (accept) begin
                    pend_v  <= 1'b1;
                    pend_pc <= redirect_pc_i;
                end
                if (state == FETCH && !imem_ack_i && !stall_i)
                    valid_d_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: scenario tasks plus a randomized run against a behavioural fetch model.
module tb_fetch_pc_unit;
    logic        clk = 1'b0, rst_n = 1'b0, stall = 1'b0, redir = 1'b0, ack = 1'b0;
    logic [31:0] rpc = '0;
    logic        req, valid_d;
    logic [31:0] addr, rdata, instr_d, pc4_d;
    logic [97:0] obs;
    int          n_chk = 0, n_fail = 0;

    fetch_pc_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall),
        .redirect_i    (redir),
        .redirect_pc_i (rpc),
        .imem_req_o    (req),
        .imem_addr_o   (addr),
        .imem_ack_i    (ack),
        .imem_rdata_i  (rdata),
        .instr_d_o     (instr_d),
        .pc4_d_o       (pc4_d),
        .valid_d_o     (valid_d)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign rdata = mem(addr);
    assign obs   = {req, addr, instr_d, pc4_d, valid_d};

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start(input int n);
        rst_n = 1'b0; ack = 1'b0; stall = 1'b0; redir = 1'b0;
        step();
        rst_n = 1'b1; ack = 1'b1;
        repeat (n) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ack = 1'b0; stall = 1'b0; redir = 1'b0;
        step();
        step();
        n_chk++;
        if (obs !== {1'b0, 32'h3000, 32'h0, 32'h0, 1'b0}) begin
            n_fail++; $display("FAIL reset_values: got %h want %h", obs, {1'b0, 32'h3000, 32'h0, 32'h0, 1'b0});
        end
    endtask

    task automatic test_sequential();
        start(1);
        n_chk++;
        if (obs !== {1'b1, 32'h3000, 32'h0, 32'h0, 1'b0}) begin
            n_fail++; $display("FAIL first_req: got %h want %h", obs, {1'b1, 32'h3000, 32'h0, 32'h0, 1'b0});
        end
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            a = 32'h3000 + 32'(4 * i);
            step();
            n_chk++;
            if (obs !== {1'b1, a + 32'd4, mem(a), a + 32'd4, 1'b1}) begin
                n_fail++; $display("FAIL seq_%0d: got %h want %h", i, obs, {1'b1, a + 32'd4, mem(a), a + 32'd4, 1'b1});
            end
        end
    endtask

    task automatic test_branch();
        redir = 1'b1; rpc = 32'h3100;
        step();
        redir = 1'b0;
        n_chk++;
        if (obs !== {1'b1, 32'h3100, mem(32'h300C), 32'h3010, 1'b1}) begin
            n_fail++; $display("FAIL branch_delay_slot: got %h want %h", obs, {1'b1, 32'h3100, mem(32'h300C), 32'h3010, 1'b1});
        end
        step();
        n_chk++;
        if (obs !== {1'b1, 32'h3104, mem(32'h3100), 32'h3104, 1'b1}) begin
            n_fail++; $display("FAIL branch_target: got %h want %h", obs, {1'b1, 32'h3104, mem(32'h3100), 32'h3104, 1'b1});
        end
    endtask

    task automatic test_wait_redirect();
        start(4);
        ack = 1'b0; redir = 1'b1; rpc = 32'h3100;
        for (int i = 0; i < 3; i++) begin
            step();
            redir = 1'b0;
            n_chk++;
            if (obs !== {1'b1, 32'h300C, mem(32'h3008), 32'h300C, 1'b0}) begin
                n_fail++; $display("FAIL wait_bubble_%0d: got %h want %h", i, obs, {1'b1, 32'h300C, mem(32'h3008), 32'h300C, 1'b0});
            end
        end
        ack = 1'b1;
        step();
        n_chk++;
        if (obs !== {1'b1, 32'h3100, mem(32'h300C), 32'h3010, 1'b1}) begin
            n_fail++; $display("FAIL wait_then_target: got %h want %h", obs, {1'b1, 32'h3100, mem(32'h300C), 32'h3010, 1'b1});
        end
    endtask

    task automatic test_stall_hold();
        start(2);
        stall = 1'b1; redir = 1'b1; rpc = 32'h5000;
        for (int i = 0; i < 2; i++) begin
            step();
            n_chk++;
            if (obs !== {1'b0, 32'h3004, mem(32'h3000), 32'h3004, 1'b1}) begin
                n_fail++; $display("FAIL hold_%0d: got %h want %h", i, obs, {1'b0, 32'h3004, mem(32'h3000), 32'h3004, 1'b1});
            end
        end
        stall = 1'b0; redir = 1'b0;
        step();
        n_chk++;
        if (obs !== {1'b1, 32'h3008, mem(32'h3004), 32'h3008, 1'b1}) begin
            n_fail++; $display("FAIL hold_release: got %h want %h", obs, {1'b1, 32'h3008, mem(32'h3004), 32'h3008, 1'b1});
        end
        step();
        n_chk++;
        if (obs !== {1'b1, 32'h300C, mem(32'h3008), 32'h300C, 1'b1}) begin
            n_fail++; $display("FAIL hold_resume: got %h want %h", obs, {1'b1, 32'h300C, mem(32'h3008), 32'h300C, 1'b1});
        end
    endtask

    task automatic test_hold_redirect();
        start(2);
        stall = 1'b1;
        step();
        stall = 1'b0; redir = 1'b1; rpc = 32'h4000;
        step();
        redir = 1'b0;
        n_chk++;
        if (obs !== {1'b1, 32'h4000, mem(32'h3004), 32'h3008, 1'b1}) begin
            n_fail++; $display("FAIL hold_redirect_slot: got %h want %h", obs, {1'b1, 32'h4000, mem(32'h3004), 32'h3008, 1'b1});
        end
        step();
        n_chk++;
        if (obs !== {1'b1, 32'h4004, mem(32'h4000), 32'h4004, 1'b1}) begin
            n_fail++; $display("FAIL hold_redirect_target: got %h want %h", obs, {1'b1, 32'h4004, mem(32'h4000), 32'h4004, 1'b1});
        end
    endtask

    task automatic test_reset_midfetch();
        start(3);
        ack = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        n_chk++;
        if (obs !== {1'b0, 32'h3000, 32'h0, 32'h0, 1'b0}) begin
            n_fail++; $display("FAIL midfetch_reset: got %h want %h", obs, {1'b0, 32'h3000, 32'h0, 32'h0, 1'b0});
        end
        ack = 1'b1;
        step();
        n_chk++;
        if (obs !== {1'b0, 32'h3000, 32'h0, 32'h0, 1'b0}) begin
            n_fail++; $display("FAIL ack_in_reset: got %h want %h", obs, {1'b0, 32'h3000, 32'h0, 32'h0, 1'b0});
        end
        ack = 1'b0; rst_n = 1'b1;
        step();
        n_chk++;
        if (obs !== {1'b1, 32'h3000, 32'h0, 32'h0, 1'b0}) begin
            n_fail++; $display("FAIL post_reset_req: got %h want %h", obs, {1'b1, 32'h3000, 32'h0, 32'h0, 1'b0});
        end
        ack = 1'b1;
        step();
        n_chk++;
        if (obs !== {1'b1, 32'h3004, mem(32'h3000), 32'h3004, 1'b1}) begin
            n_fail++; $display("FAIL post_reset_fetch: got %h want %h", obs, {1'b1, 32'h3004, mem(32'h3000), 32'h3004, 1'b1});
        end
    endtask

    // Model view: an architectural fetch address, a remembered redirect target,
    // and an optional word parked for a stalled decode.
    task automatic test_random();
        logic [31:0] m_pc, m_pend_pc, m_buf_w, m_instr, m_pc4, nxt;
        logic        m_pend_v, m_buf, m_started, m_valid, take;
        logic [97:0] exp_obs;
        rst_n = 1'b0; ack = 1'b0; stall = 1'b0; redir = 1'b0;
        step();
        m_pc = 32'h3000; m_pend_v = 1'b0; m_pend_pc = '0; m_buf = 1'b0; m_buf_w = '0;
        m_started = 1'b0; m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            exp_obs = {m_started && !m_buf, m_pc, m_instr, m_pc4, m_valid};
            n_chk++;
            if (obs !== exp_obs) begin
                n_fail++;
                if (n_fail < 20) $display("FAIL random_cycle_%0d: got %h want %h", c, obs, exp_obs);
            end
            rst_n = $urandom_range(0, 99) != 0;
            ack   = $urandom_range(0, 2) != 0;
            stall = $urandom_range(0, 3) == 0;
            redir = $urandom_range(0, 4) == 0;
            rpc   = $urandom & 32'hFFFF_FFFC;
            @(posedge clk);
            take = redir && !stall;
            nxt  = take ? rpc : m_pend_v ? m_pend_pc : m_pc + 32'd4;
            if (!rst_n) begin
                m_pc = 32'h3000; m_pend_v = 1'b0; m_buf = 1'b0; m_started = 1'b0;
                m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
            end else if (!m_started || (!m_buf && !ack)) begin
                if (m_started && !stall) m_valid = 1'b0;
                if (take) begin m_pend_v = 1'b1; m_pend_pc = rpc; end
                m_started = 1'b1;
            end else if (!m_buf && stall) begin
                m_buf = 1'b1; m_buf_w = mem(m_pc);
            end else if (!stall) begin
                m_instr = m_buf ? m_buf_w : mem(m_pc);
                m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
                m_pc = nxt; m_pend_v = 1'b0; m_buf = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_wait_redirect();
        test_stall_hold();
        test_hold_redirect();
        test_reset_midfetch();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Fetch-stage PC generator and F/D pipeline register for the 5-stage MIPS core. It is the consumer of the decode-stage branch/jump target and taken decision. It owns the architectural fetch PC and issues one-outstanding instruction-memory reads with a req/ack handshake. It honours MIPS branch delay slots, absorbs memory wait states and decode stalls, and presents `instr_d_o` / `pc4_d_o` to decode.

## Interface
- `RESET_PC`, 32'h0000_3000, first fetch address after reset

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous reset, active-low
- `stall_i`  in  1  hazard unit: freeze F/D register
- `redirect_i`  in  1  decode: branch taken or J/JAL/JR resolved; sampled only when `stall_i`=0
- `redirect_pc_i`  in  32  decode target address
- `imem_req_o`  out  1  fetch request
- `imem_addr_o`  out  32  fetch address, word aligned
- `imem_ack_i`  in  1  read data valid this cycle; may assert in the same cycle as req
- `imem_rdata_i`  in  32  instruction word
- `instr_d_o`  out  32  F/D instruction
- `pc4_d_o`  out  32  F/D PC+4
- `valid_d_o`  out  1  F/D holds a real instruction (0 = bubble)

## Operation
- States:
  - IDLE: reset state; go to FETCH next cycle.
  - FETCH: `imem_req_o`=1; `imem_addr_o`=`pc` held stable until ack.
  - HOLD: `imem_req_o`=0; acked word is buffered in a skid register while `stall_i`=1.
- Redirect capture: `redirect_i`&!`stall_i` sets `pend_v`/`pend_pc`. A later redirect before consumption overwrites `pend_pc`; architecturally illegal, no error flag.
- Next fetch address, used when the current fetch retires:
  - `redirect_pc_i` if a redirect is accepted this cycle;
  - else `pend_pc` if `pend_v`;
  - else `pc`+4 (32-bit wrap, no trap).
  - Consuming clears `pend_v`.
- Delay slot: the word in flight or in HOLD when a redirect arrives is the delay slot. It always enters F/D. The redirect only affects the following address. No flush exists.
- FETCH with ack:
  - `stall_i`=0: F/D ← {`imem_rdata_i`, `pc`+4, 1}; `pc` ← next; stay FETCH.
  - `stall_i`=1: skid ← `imem_rdata_i`; go HOLD; F/D unchanged.
- FETCH without ack: `stall_i`=0 → `valid_d_o` ← 0; `stall_i`=1 → F/D unchanged.
- HOLD with `stall_i`=0: F/D ← {skid, `pc`+4, 1}; `pc` ← next (a redirect accepted this cycle applies); go FETCH.
- Reset, including mid-fetch:
  - State ← IDLE, `pc` ← `RESET_PC`, `pend_v` ← 0.
  - An ack arriving while `rst_n`=0 is ignored. Instruction memory must tolerate req dropping without ack.

## Timing
- Reset values: `imem_req_o`=0, `imem_addr_o`=`RESET_PC`, `instr_d_o`=0, `pc4_d_o`=0, `valid_d_o`=0.
- First req occurs in the cycle after the first edge with `rst_n`=1.
- Zero-wait memory: 1 instruction/cycle. Latency from address to F/D is 1 edge.
- N wait cycles produce N bubbles (`valid_d_o`=0) when not stalled.
- Redirect accepted at edge k with ack tied high:
  - delay slot in F/D after edge k;
  - `imem_addr_o`=target in cycle k+1;
  - target instruction in F/D after edge k+1.
- HOLD release: skid word appears in F/D one edge after `stall_i` falls. The next req is issued in the following cycle.

## Structure
- Shared `pipe_pkg` holds:
  - `RESET_PC_DEFAULT`;
  - the `fetch_state_t` enum {IDLE, FETCH, HOLD};
  - `INSTR_W`=32.
- One sub-module, `fetch_skid_buf`: 32-bit skid register with load/valid. The FSM, PC and pending-redirect logic stay in `fetch_pc_unit`.

## Test plan
- Reset then ack tied high → req in cycle 1 at 0x3000, then 0x3004, 0x3008; `valid_d_o`=1 from cycle 2; `pc4_d_o` 0x3004, 0x3008, 0x300C.
- Branch at 0x3008 in D, `redirect_i` with `redirect_pc_i`=0x3100, ack tied high → F/D sequence 0x300C (delay slot, `pc4_d_o`=0x3010), then 0x3100.
- Ack delayed 3 cycles on 0x300C with redirect to 0x3100 during the wait:
  - `valid_d_o`=0 for 3 cycles, address held at 0x300C;
  - after ack, `imem_addr_o`=0x3100.
- `stall_i`=1 coincident with ack of 0x3004:
  - HOLD, req low, F/D keeps 0x3000 word;
  - `stall_i` falls → F/D = 0x3004 word, next req at 0x3008.
- `rst_n` low while req high and ack pending:
  - next edge restores all reset values;
  - ack pulse during reset has no effect;
  - after release, first address is 0x3000.
- Redirect while stalled in HOLD is ignored until `stall_i`=0. Redirect on the release cycle to 0x4000 → skid word enters F/D, next address 0x4000.
